// File: rtl/fuzz_sig_pkg.sv
// Shared types and the MISR step for the fuzz-harness signature compactor.
// The step function works on a fixed 64-bit container, so SIG_W may not exceed SIG_MAX.
package fuzz_sig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sig_state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;
    localparam int unsigned SIG_MAX      = 64;

    // One MISR step on the low w bits: shift left, feed back POLY on MSB, inject f.
    function automatic logic [SIG_MAX-1:0] misr_step(
        input logic [SIG_MAX-1:0] sig,
        input logic [SIG_MAX-1:0] poly,
        input logic [SIG_MAX-1:0] f,
        input int unsigned        w
    );
        logic [SIG_MAX-1:0] mask;
        logic [SIG_MAX-1:0] res;
        logic [5:0]         msb_idx;
        mask    = {SIG_MAX{1'b1}} >> (SIG_MAX - w);
        msb_idx = 6'(w - 32'd1);
        res     = (sig << 1) ^ f;
        if (sig[msb_idx]) begin
            res = res ^ poly;
        end else begin
            res = res;
        end
        return res & mask;
    endfunction

endpackage

// File: rtl/sig_fold.sv
// Combinational XOR fold of a wide bus into one SIG_W-bit word.
// The bus is zero-extended to a whole number of slices before folding.
module sig_fold
    import fuzz_sig_pkg::*;
#(
    parameter int WIDTH = 81,
    parameter int SIG_W = 32
) (
    input  logic [WIDTH-1:0] wire0,
    output logic [SIG_W-1:0] f
);

    localparam int NSLICE = (WIDTH + SIG_W - 1) / SIG_W;

    logic [NSLICE*SIG_W-1:0] ext;

    // Zero-extend and XOR all slices together.
    always_comb begin
        ext              = '0;
        ext[WIDTH-1:0]   = wire0;
        f                = '0;
        for (int i = 0; i < NSLICE; i++) begin
            f = f ^ ext[i*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/sig_compactor.sv
// Multi-cycle signature compactor: folds wire0 each cycle into a MISR over a
// window of CYCLES samples, then holds the signature with done raised.
module sig_compactor
    import fuzz_sig_pkg::*;
#(
    parameter int               WIDTH  = 81,
    parameter int               SIG_W  = 32,
    parameter int               CYCLES = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEFAULT_SEED),
    parameter int               CNT_W  = $clog2(CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] wire0,
    output logic [SIG_W-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    sig_state_t         state;
    logic [SIG_W-1:0]   f;
    logic [SIG_MAX-1:0] step_full;
    logic [SIG_W-1:0]   next_sig;

    sig_fold #(
        .WIDTH (WIDTH),
        .SIG_W (SIG_W)
    ) u_fold (
        .wire0 (wire0),
        .f     (f)
    );

    // Next MISR value from the current signature and this cycle's fold.
    always_comb begin
        step_full = misr_step(SIG_MAX'(y), SIG_MAX'(POLY), SIG_MAX'(f), SIG_W);
        next_sig  = step_full[SIG_W-1:0];
    end

    // Capture FSM with signature, sample counter and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        y     <= SEED;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= state;
                    end
                end
                RUN: begin
                    // start is deliberately ignored: a window only ends on count or rst.
                    y     <= next_sig;
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    y     <= '0;
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_compactor.sv
// Scoreboard bench for sig_compactor: five instances cover the default and
// the directed SEED/CYCLES configurations; expected signatures come from a bit-level model.
module tb_sig_compactor;

    localparam int W = 81;
    typedef logic [W-1:0] word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  start;
    word_t       wire0;
    logic [31:0] y_o [5];
    logic        busy_o [5];
    logic        done_o [5];
    logic [4:0]  cnt_def;
    logic [4:0]  cnt_zero;
    logic [1:0]  cnt_shift;
    logic [0:0]  cnt_fold;
    logic [0:0]  cnt_fb;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    sig_compactor u_def (.clk(clk), .rst(rst), .start(start[0]), .wire0(wire0),
        .y(y_o[0]), .busy(busy_o[0]), .done(done_o[0]), .count(cnt_def));
    sig_compactor #(.SEED(32'h0), .CYCLES(16)) u_zero (.clk(clk), .rst(rst), .start(start[1]),
        .wire0(wire0), .y(y_o[1]), .busy(busy_o[1]), .done(done_o[1]), .count(cnt_zero));
    sig_compactor #(.SEED(32'h0), .CYCLES(2)) u_shift (.clk(clk), .rst(rst), .start(start[2]),
        .wire0(wire0), .y(y_o[2]), .busy(busy_o[2]), .done(done_o[2]), .count(cnt_shift));
    sig_compactor #(.SEED(32'h0), .CYCLES(1)) u_fold1 (.clk(clk), .rst(rst), .start(start[3]),
        .wire0(wire0), .y(y_o[3]), .busy(busy_o[3]), .done(done_o[3]), .count(cnt_fold));
    sig_compactor #(.SEED(32'h80000000), .CYCLES(1)) u_fb (.clk(clk), .rst(rst), .start(start[4]),
        .wire0(wire0), .y(y_o[4]), .busy(busy_o[4]), .done(done_o[4]), .count(cnt_fb));

    function automatic logic [31:0] cnt_of(input int idx);
        case (idx)
            0:       return {27'd0, cnt_def};
            1:       return {27'd0, cnt_zero};
            2:       return {30'd0, cnt_shift};
            3:       return {31'd0, cnt_fold};
            4:       return {31'd0, cnt_fb};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Reference fold: bit i of the bus lands on bit i mod 32.
    function automatic logic [31:0] fold_ref(input word_t d);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < W; i++) r[i % 32] = r[i % 32] ^ d[i];
        return r;
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] r;
        r = {s[30:0], 1'b0} ^ f;
        if (s[31]) r = r ^ 32'h04C11DB7;
        return r;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One capture window on instance idx; start may already be high (reseed from DONE).
    task automatic run_window(input int idx, input logic [31:0] seed, input int n,
                              input word_t d [$], input int pulse_at, input bit keep_start,
                              output logic [31:0] obs);
        logic [31:0] e;
        int          waited;
        e = seed;
        foreach (d[i]) e = misr_ref(e, fold_ref(d[i]));
        exp_q.push_back(e);
        if (!start[idx]) begin
            @(negedge clk);
            start[idx] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_value("seed_load", y_o[idx], seed);
                check_value("count_start", cnt_of(idx), 32'd0);
            end
            check_value("busy_run", {31'd0, busy_o[idx]}, 32'd1);
            check_value("done_early", {31'd0, done_o[idx]}, 32'd0);
            start[idx] = (i == pulse_at) ? 1'b1 : 1'b0;
            wire0 = d[i];
        end
        start[idx] = 1'b0;
        @(negedge clk);
        waited = 0;
        while (!done_o[idx] && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check_value("done_latency", waited, 32'd0);
        check_value("signature", y_o[idx], exp_q.pop_front());
        check_value("count_final", cnt_of(idx), n);
        check_value("busy_fall", {31'd0, busy_o[idx]}, 32'd0);
        obs = y_o[idx];
        if (keep_start) start[idx] = 1'b1;
    endtask

    task automatic rand_words(input int n, output word_t q [$]);
        logic [95:0] t;
        q.delete();
        for (int i = 0; i < n; i++) begin
            t = {$urandom(), $urandom(), $urandom()};
            q.push_back(t[W-1:0]);
        end
    endtask

    initial begin
        word_t       q [$];
        word_t       t;
        logic [31:0] obs;
        logic [31:0] first;

        rst   = 1'b1;
        start = 5'd0;
        wire0 = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_value("rst_y", y_o[i], 32'd0);
            check_value("rst_count", cnt_of(i), 32'd0);
            check_value("rst_busy", {31'd0, busy_o[i]}, 32'd0);
            check_value("rst_done", {31'd0, done_o[i]}, 32'd0);
        end
        rst = 1'b0;

        q.delete();
        repeat (16) q.push_back('0);
        run_window(1, 32'h0, 16, q, -1, 1'b0, obs);
        check_value("zero_data", obs, 32'h0);

        q = {word_t'(1), word_t'(0)};
        run_window(2, 32'h0, 2, q, -1, 1'b0, obs);
        check_value("shift_path", obs, 32'h00000002);

        t = '0;
        t[0]  = 1'b1;
        t[32] = 1'b1;
        q = {t};
        run_window(3, 32'h0, 1, q, -1, 1'b0, obs);
        check_value("fold_cancel", obs, 32'h0);
        t = '0;
        t[64] = 1'b1;
        q = {t};
        run_window(3, 32'h0, 1, q, -1, 1'b0, obs);
        check_value("fold_top_slice", obs, 32'h00000001);

        q = {word_t'(0)};
        run_window(4, 32'h80000000, 1, q, -1, 1'b0, obs);
        check_value("feedback", obs, 32'h04C11DB7);

        // Pulse start mid-window, then hold it in DONE for an immediate reseed.
        rand_words(16, q);
        run_window(0, 32'hFFFFFFFF, 16, q, 3, 1'b1, first);
        run_window(0, 32'hFFFFFFFF, 16, q, -1, 1'b0, obs);
        check_value("repeat_identical", obs, first);

        // Reset mid-window at count 5, with start also high on the reset edge.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 10 && cnt_of(0) != 32'd5; i++) begin
            wire0 = ~wire0;
            @(negedge clk);
        end
        check_value("reach_count5", cnt_of(0), 32'd5);
        rst      = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start[0] = 1'b0;
        check_value("midrst_y", y_o[0], 32'd0);
        check_value("midrst_count", cnt_of(0), 32'd0);
        check_value("midrst_busy", {31'd0, busy_o[0]}, 32'd0);
        check_value("midrst_done", {31'd0, done_o[0]}, 32'd0);
        repeat (3) @(negedge clk);
        check_value("idle_wait_busy", {31'd0, busy_o[0]}, 32'd0);
        check_value("idle_wait_count", cnt_of(0), 32'd0);

        for (int k = 0; k < 3; k++) begin
            rand_words(16, q);
            run_window(0, 32'hFFFFFFFF, 16, q, -1, 1'b0, obs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
